// File: rtl/if_pkg.sv
// if_pkg: shared definitions for the instruction-fetch stage.
//   fetch_state_e  : fetch FSM states (IDLE, REQ, WAIT, HOLD)
//   RESET_PC_DEF   : default PC loaded by reset
//   NOP_INST_DEF   : default IF/ID instruction word after reset or flush
package if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry {pc, inst} buffer that parks a fetch response
// while decode is stalled.
//   clk, rst          : clock, asynchronous active-high reset
//   i_load            : capture i_pc/i_inst and mark the entry valid
//   i_release         : entry consumed by IF/ID, mark empty
//   i_clear           : entry dropped by a flush, mark empty
//   i_pc, i_inst      : response to capture
//   o_valid/o_pc/o_inst : buffered entry
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_release,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_clear || i_release) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Owns the fetch PC, runs the single-
// outstanding imem request/response handshake and loads the IF/ID register.
//   clk, rst                : clock, asynchronous active-high reset
//   npc                     : next PC from the next-PC selector
//   redirect                : control-hazard flush, target on npc
//   id_stall                : decode cannot accept this cycle
//   imem_req/imem_addr      : fetch request
//   imem_ready              : request accepted
//   imem_rvalid/imem_rdata  : fetch response
//   if_pc                   : current fetch PC
//   id_valid/id_pc/id_inst  : IF/ID register
// Optional feature macro: IF_PREFETCH_EN issues the next request in the
// same cycle a response is consumed (1 instruction/cycle at 1-cycle latency).
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        redirect,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic         r_kill;
  logic         w_kill_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         r_id_valid;
  logic         w_id_valid_nxt;
  logic [31:0]  r_id_pc;
  logic [31:0]  w_id_pc_nxt;
  logic [31:0]  r_id_inst;
  logic [31:0]  w_id_inst_nxt;
  logic         w_req;
  logic [31:0]  w_addr;

  logic         w_buf_load;
  logic         w_buf_release;
  logic         w_buf_clear;
  logic         w_buf_valid;
  logic [31:0]  w_buf_pc;
  logic [31:0]  w_buf_inst;

  fetch_hold_buf u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_buf_load),
    .i_release (w_buf_release),
    .i_clear   (w_buf_clear),
    .i_pc      (r_pc),
    .i_inst    (imem_rdata),
    .o_valid   (w_buf_valid),
    .o_pc      (w_buf_pc),
    .o_inst    (w_buf_inst)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_kill_nxt     = r_kill;
    w_pc_nxt       = r_pc;
    // Without a stall, IF/ID empties unless something below loads it.
    w_id_valid_nxt = id_stall ? r_id_valid : 1'b0;
    w_id_pc_nxt    = r_id_pc;
    w_id_inst_nxt  = r_id_inst;
    w_buf_load     = 1'b0;
    w_buf_release  = 1'b0;
    w_buf_clear    = 1'b0;
    w_req          = 1'b0;
    w_addr         = r_pc;

    // Flush overrides stall and any IF/ID load decided below.
    if (redirect && (r_state != IDLE)) begin
      w_pc_nxt       = npc;
      w_id_valid_nxt = 1'b0;
      w_id_inst_nxt  = NOP_INST;
    end

    unique case (r_state)
      IDLE: w_state_nxt = REQ;

      REQ: begin
        w_req = 1'b1;
        if (imem_ready) begin
          w_state_nxt = WAIT;
          // The accepted request is for the pre-redirect PC; drop its reply.
          if (redirect) w_kill_nxt = 1'b1;
        end
      end

      WAIT: begin
        if (redirect) begin
          if (imem_rvalid) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = REQ;
          end else begin
            w_kill_nxt  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (r_kill) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = REQ;
          end else if (!id_stall) begin
            w_id_valid_nxt = 1'b1;
            w_id_pc_nxt    = r_pc;
            w_id_inst_nxt  = imem_rdata;
            w_pc_nxt       = npc;
`ifdef IF_PREFETCH_EN
            w_req       = 1'b1;
            w_addr      = npc;
            w_state_nxt = imem_ready ? WAIT : REQ;
`else
            w_state_nxt = REQ;
`endif
          end else begin
            w_buf_load  = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          w_buf_clear = 1'b1;
          w_state_nxt = REQ;
        end else if (!id_stall) begin
          w_buf_release  = 1'b1;
          w_id_valid_nxt = w_buf_valid;
          w_id_pc_nxt    = w_buf_pc;
          w_id_inst_nxt  = w_buf_inst;
          w_pc_nxt       = npc;
          w_state_nxt    = REQ;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_kill     <= 1'b0;
      r_pc       <= RESET_PC;
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_inst  <= NOP_INST;
    end else begin
      r_state    <= w_state_nxt;
      r_kill     <= w_kill_nxt;
      r_pc       <= w_pc_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_id_pc    <= w_id_pc_nxt;
      r_id_inst  <= w_id_inst_nxt;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = w_addr;
  assign if_pc     = r_pc;
  assign id_valid  = r_id_valid;
  assign id_pc     = r_id_pc;
  assign id_inst   = r_id_inst;

endmodule
